// File: rtl/wb_picorv_bridge.sv
// wb_picorv_bridge: PicoRV32 native memory port to pipelined Wishbone master.
// One outstanding request at a time. An address-range check, a bus-cycle
// timeout and first-fault capture all report through a single error event.
module wb_picorv_bridge #(
    parameter int          AW             = 30,
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_mem_valid,
    input  logic          i_mem_instr,
    input  logic [31:0]   i_mem_addr,
    input  logic [31:0]   i_mem_wdata,
    input  logic [3:0]    i_mem_wstrb,
    output logic          o_mem_ready,
    output logic [31:0]   o_mem_rdata,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic [31:0]   i_wb_data,
    input  logic          i_wb_err,
    output logic          o_err_irq,
    output logic          o_fault_valid,
    output logic [31:0]   o_fault_addr,
    output logic          o_fault_instr,
    input  logic          i_fault_clear
);

    // Counter is wide enough to hold TIMEOUT_CYCLES; keep one bit when timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Byte-address bits above the Wishbone window; empty when AW covers the full 32-bit space.
    localparam logic [31:0] HI_MASK = (AW >= 30) ? 32'h0 : ~((32'h1 << (AW + 2)) - 32'h1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t          r_state;
    logic [31:0]     r_req_addr;
    logic            r_req_instr;
    logic [CW-1:0]   r_tmo_cnt;

    logic            w_oor;
    logic            w_timeout;
    logic            w_bus_fail;
    logic            w_req_fail;
    logic            w_err_evt;
    logic [31:0]     w_evt_addr;
    logic            w_evt_instr;

    assign o_wb_addr   = r_req_addr[AW+1:2];
    assign w_oor       = |(i_mem_addr & HI_MASK);
    // The counter started at 0 on the first cyc cycle, so T-1 means this is the T-th cycle.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && o_wb_cyc && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    // Error beats ack when both arrive together.
    assign w_bus_fail  = (r_state == S_BUS) && (i_wb_err || w_timeout);
    assign w_req_fail  = (r_state == S_IDLE) && i_mem_valid && w_oor;
    assign w_err_evt   = w_bus_fail || w_req_fail;
    // A range fault is reported straight from the request; bus faults from the latched request.
    assign w_evt_addr  = (r_state == S_IDLE) ? i_mem_addr  : r_req_addr;
    assign w_evt_instr = (r_state == S_IDLE) ? i_mem_instr : r_req_instr;

    // Bus-cycle timeout counter: cleared while idle, saturating while cyc is high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_tmo_cnt <= '0;
        else if (!o_wb_cyc)
            r_tmo_cnt <= '0;
        else if (r_tmo_cnt != CW'(TIMEOUT_CYCLES))
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end

    // Request FSM: IDLE accepts, BUS runs the Wishbone cycle, DONE gives the core a cycle to drop valid.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_req_instr <= 1'b0;
            o_mem_ready <= 1'b0;
            o_mem_rdata <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_err_irq   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_mem_valid) begin
                        if (w_oor) begin
                            o_mem_ready <= 1'b1;
                            o_mem_rdata <= ERR_DATA;
                            o_err_irq   <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_req_addr  <= i_mem_addr;
                            r_req_instr <= i_mem_instr;
                            o_wb_we     <= |i_mem_wstrb;
                            o_wb_sel    <= (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
                            o_wb_data   <= i_mem_wdata;
                            o_wb_cyc    <= 1'b1;
                            o_wb_stb    <= 1'b1;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (o_wb_stb && !i_wb_stall)
                        o_wb_stb <= 1'b0;
                    if (w_bus_fail || i_wb_ack) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_mem_ready <= 1'b1;
                        o_mem_rdata <= w_bus_fail ? ERR_DATA : i_wb_data;
                        o_err_irq   <= w_bus_fail;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    o_mem_ready <= 1'b0;
                    o_err_irq   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // First-fault latch: a new error captured in the clear cycle wins over the clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fault_valid <= 1'b0;
            o_fault_addr  <= '0;
            o_fault_instr <= 1'b0;
        end else if (w_err_evt && (!o_fault_valid || i_fault_clear)) begin
            o_fault_valid <= 1'b1;
            o_fault_addr  <= w_evt_addr;
            o_fault_instr <= w_evt_instr;
        end else if (i_fault_clear) begin
            o_fault_valid <= 1'b0;
        end
    end

endmodule
